// File: rtl/irq_vector_ctrl_pkg.sv
// irq_vector_ctrl_pkg
// Shared definitions for the interrupt vector controller:
//   - default channel-number and instruction-memory address widths
//   - default vector-table reset entry base and stride (word addresses)
//   - request FSM state encoding
//   - helper computing a channel's reset entry
package irq_vector_ctrl_pkg;

    // Default channel-number width (2**NBIT_IRQ must cover the channel count).
    localparam int unsigned NBIT_IRQ     = 2;
    // Instruction-memory word-address width.
    localparam int unsigned IM_ADDR_NBIT = 10;

    // Channel 0 resets to word 'h123 (byte 'h48c); channels are 'h20 words apart.
    localparam int unsigned DEF_ENTR_BASE   = 'h123;
    localparam int unsigned DEF_ENTR_STRIDE = 'h20;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } irq_state_e;

    // Untruncated reset entry for channel ch; the caller narrows it to its
    // address width.
    function automatic int unsigned entr_reset(input int unsigned base,
                                               input int unsigned stride,
                                               input int unsigned ch);
        return base + ch * stride;
    endfunction

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// irq_vector_ctrl_if
// Bundles every non-clock/reset signal of the interrupt vector controller.
//   master : the controller side (consumes sources, mask, table writes,
//            ack/eret; drives the request, channel, entry and in-service set)
//   slave  : the core / source side, directions mirrored
// Signals:
//   irq_src[NCH]    raw level interrupt sources
//   irq_mask[NCH]   1 = channel enabled
//   vt_we/vt_idx/vt_data   vector-table write port
//   irq_req/irq_num/irq_entr   registered request to the core
//   irq_ack         core accepts the request (pulse)
//   eret            core returns from the current ISR (pulse)
//   in_service[NCH] channels currently being serviced
interface irq_vector_ctrl_if
    import irq_vector_ctrl_pkg::*;
#(
    parameter int unsigned NCH  = 3,
    parameter int unsigned NBIT = NBIT_IRQ,
    parameter int unsigned AW   = IM_ADDR_NBIT
);

    logic [NCH-1:0]  irq_src;
    logic [NCH-1:0]  irq_mask;
    logic            vt_we;
    logic [NBIT-1:0] vt_idx;
    logic [AW-1:0]   vt_data;
    logic            irq_req;
    logic [NBIT-1:0] irq_num;
    logic [AW-1:0]   irq_entr;
    logic            irq_ack;
    logic            eret;
    logic [NCH-1:0]  in_service;

    modport master (
        input  irq_src,
        input  irq_mask,
        input  vt_we,
        input  vt_idx,
        input  vt_data,
        input  irq_ack,
        input  eret,
        output irq_req,
        output irq_num,
        output irq_entr,
        output in_service
    );

    modport slave (
        output irq_src,
        output irq_mask,
        output vt_we,
        output vt_idx,
        output vt_data,
        output irq_ack,
        output eret,
        input  irq_req,
        input  irq_num,
        input  irq_entr,
        input  in_service
    );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   req[NCH]    request vector
//   valid       any bit of req set
//   idx[NBIT]   index of the lowest set bit (0 when valid is low)
module irq_prio_enc #(
    parameter int unsigned NCH  = 3,
    parameter int unsigned NBIT = 2
) (
    input  logic [NCH-1:0]  req,
    output logic            valid,
    output logic [NBIT-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = NBIT'(i);
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
// Interrupt controller for the core: captures rising edges on NCH level
// sources, masks them, arbitrates by fixed priority (channel 0 highest) and
// presents one registered {channel, ISR entry} request through a req/ack
// handshake. A runtime-writable vector table supplies the entries; channels
// stay in service until the core signals eret.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   irq_vector_ctrl_if.master (sources, mask, table write port,
//         request/ack, eret, in-service set)
// Build option:
//   IRQ_NESTING_EN  when defined, a channel strictly higher in priority than
//                   every in-service channel may preempt (nested ISRs);
//                   otherwise a new request waits until nothing is in service.
module irq_vector_ctrl
    import irq_vector_ctrl_pkg::*;
#(
    parameter int unsigned NCH         = 3,
    parameter int unsigned NBIT        = NBIT_IRQ,
    parameter int unsigned AW          = IM_ADDR_NBIT,
    parameter int unsigned ENTR_BASE   = DEF_ENTR_BASE,
    parameter int unsigned ENTR_STRIDE = DEF_ENTR_STRIDE
) (
    input logic                clk,
    input logic                rst,
    irq_vector_ctrl_if.master  bus
);

    irq_state_e      state_q, state_d;
    logic [NCH-1:0]  src_q;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  in_service_q, in_service_d;
    logic [NBIT-1:0] num_q, num_d;
    logic [AW-1:0]   entr_q, entr_d;
    logic [AW-1:0]   vt_q [NCH];

    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  preempt_ok;
    logic            win_valid;
    logic [NBIT-1:0] win_idx;
    logic [AW-1:0]   win_entr;
    logic            isv_valid;
    logic [NBIT-1:0] isv_idx;
    logic [NCH-1:0]  isv_oh;
    logic [NCH-1:0]  num_oh;
    logic            ack_take;
    logic            sel_enabled;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    assign elig = pending_q & bus.irq_mask & ~in_service_q & preempt_ok;

    irq_prio_enc #(
        .NCH  (NCH),
        .NBIT (NBIT)
    ) u_win_enc (
        .req   (elig),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Lowest in-service channel: the one eret retires, and the preemption
    // threshold when nesting is enabled.
    irq_prio_enc #(
        .NCH  (NCH),
        .NBIT (NBIT)
    ) u_isv_enc (
        .req   (in_service_q),
        .valid (isv_valid),
        .idx   (isv_idx)
    );

`ifdef IRQ_NESTING_EN
    always_comb begin
        preempt_ok = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            preempt_ok[i] = !isv_valid || (i < int'(isv_idx));
        end
    end
`else
    assign preempt_ok = {NCH{~isv_valid}};
`endif

    // Decode the latched channel and the lowest in-service channel; also
    // mux the winner's table entry without indexing past NCH.
    always_comb begin
        num_oh   = '0;
        isv_oh   = '0;
        win_entr = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            num_oh[i] = (num_q == NBIT'(i));
            isv_oh[i] = (isv_idx == NBIT'(i));
            if (win_idx == NBIT'(i)) begin
                win_entr = vt_q[i];
            end
        end
    end

    assign ack_take    = (state_q == StReq) && bus.irq_ack;
    assign sel_enabled = |(num_oh & bus.irq_mask);

    // ---------------------------------------------------------------------
    // Request FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        entr_d  = entr_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StReq;
                    num_d   = win_idx;
                    entr_d  = win_entr;
                end
            end
            StReq: begin
                // Request is frozen until accepted or its channel is masked.
                if (bus.irq_ack) begin
                    state_d = StIdle;
                end else if (!sel_enabled) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // Pending and in-service bookkeeping
    // ---------------------------------------------------------------------
    always_comb begin
        // A fresh edge on the channel being acked keeps it pending.
        pending_d = pending_q;
        if (ack_take) begin
            pending_d = pending_d & ~num_oh;
        end
        pending_d = pending_d | (bus.irq_src & ~src_q);

        // eret retires the lowest in-service channel before ack adds one.
        in_service_d = in_service_q;
        if (bus.eret && isv_valid) begin
            in_service_d = in_service_d & ~isv_oh;
        end
        if (ack_take) begin
            in_service_d = in_service_d | num_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            num_q        <= '0;
            entr_q       <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= bus.irq_src;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            num_q        <= num_d;
            entr_q       <= entr_d;
        end
    end

    // ---------------------------------------------------------------------
    // Vector table; indices at or above NCH match no entry and are dropped.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (rst) begin
                vt_q[i] <= AW'(entr_reset(ENTR_BASE, ENTR_STRIDE, i));
            end else if (bus.vt_we && (bus.vt_idx == NBIT'(i))) begin
                vt_q[i] <= bus.vt_data;
            end
        end
    end

    assign bus.irq_req    = (state_q == StReq);
    assign bus.irq_num    = num_q;
    assign bus.irq_entr   = entr_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
module tb_irq_vector_ctrl;
    import irq_vector_ctrl_pkg::*;

    localparam int NCH         = 3;
    localparam int NBIT        = 2;
    localparam int AW          = 10;
    localparam int ENTR_BASE   = 'h123;
    localparam int ENTR_STRIDE = 'h20;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    irq_vector_ctrl_if #(.NCH(NCH), .NBIT(NBIT), .AW(AW)) bus ();

    irq_vector_ctrl #(
        .NCH         (NCH),
        .NBIT        (NBIT),
        .AW          (AW),
        .ENTR_BASE   (ENTR_BASE),
        .ENTR_STRIDE (ENTR_STRIDE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model (spec-level) ----------------
    logic [NCH-1:0] m_src, m_pend, m_isv;
    logic [AW-1:0]  m_vt [NCH];
    bit             m_req;
    int             m_num;
    logic [AW-1:0]  m_entr;

    function automatic int lowest(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_src = '0; m_pend = '0; m_isv = '0;
        m_req = 0; m_num = 0; m_entr = '0;
        for (int i = 0; i < NCH; i++) m_vt[i] = AW'(ENTR_BASE + i * ENTR_STRIDE);
    endtask

    task automatic model_step();
        int             lo;
        bit             ack_hit, admitted;
        logic [NCH-1:0] n_isv, n_pend;
        if (rst) begin
            model_reset();
            return;
        end
        lo      = lowest(m_isv);
        ack_hit = m_req && bus.irq_ack;
        n_isv   = m_isv;
        if (bus.eret && lo >= 0) n_isv[lo] = 1'b0;
        if (ack_hit) n_isv[m_num] = 1'b1;
        n_pend = m_pend;
        if (ack_hit) n_pend[m_num] = 1'b0;
        n_pend = n_pend | (bus.irq_src & ~m_src);
        if (m_req) begin
            if (bus.irq_ack || !bus.irq_mask[m_num]) m_req = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
`ifdef IRQ_NESTING_EN
                admitted = (lo < 0) || (i < lo);
`else
                admitted = (lo < 0);
`endif
                if (!m_req && m_pend[i] && bus.irq_mask[i] && !m_isv[i] && admitted) begin
                    m_req  = 1;
                    m_num  = i;
                    m_entr = m_vt[i];
                end
            end
        end
        if (bus.vt_we && int'(bus.vt_idx) < NCH) m_vt[bus.vt_idx] = bus.vt_data;
        m_pend = n_pend;
        m_isv  = n_isv;
        m_src  = bus.irq_src;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_src = '0; bus.irq_mask = '1; bus.vt_we = 0; bus.vt_idx = '0;
        bus.vt_data = '0; bus.irq_ack = 0; bus.eret = 0;
    endtask

    task automatic pulse_src(input logic [NCH-1:0] v);
        bus.irq_src = v; tick(); bus.irq_src = '0;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    endtask

    task automatic do_eret();
        bus.eret = 1; tick(); bus.eret = 0;
    endtask

    task automatic vt_write(input int idx, input int data);
        bus.vt_we = 1; bus.vt_idx = NBIT'(idx); bus.vt_data = AW'(data);
        tick(); bus.vt_we = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; idle_inputs(); tick(); tick(); rst = 0;
        n_tests++; if (bus.irq_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_req: got %b want 0", bus.irq_req); end
        n_tests++; if (bus.irq_num !== 2'd0) begin n_fail++;
            $display("FAIL reset_num: got %0d want 0", bus.irq_num); end
        n_tests++; if (bus.irq_entr !== 10'h0) begin n_fail++;
            $display("FAIL reset_entr: got %h want 000", bus.irq_entr); end
        n_tests++; if (bus.in_service !== 3'b000) begin n_fail++;
            $display("FAIL reset_isv: got %b want 000", bus.in_service); end
    endtask

    task automatic test_priority_sequence();
        pulse_src(3'b111);
        n_tests++; if (bus.irq_req !== 1'b0) begin n_fail++;
            $display("FAIL seq_latency: req got %b want 0 one cycle after edge", bus.irq_req); end
        tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.irq_entr} !== {1'b1, 2'd0, 10'h123}) begin
            n_fail++; $display("FAIL seq_ch0: got req=%b num=%0d entr=%h want 1/0/123",
                               bus.irq_req, bus.irq_num, bus.irq_entr); end
        do_ack();
        n_tests++; if ({bus.irq_req, bus.in_service} !== {1'b0, 3'b001}) begin n_fail++;
            $display("FAIL seq_ack0: got req=%b isv=%b want 0/001", bus.irq_req, bus.in_service); end
        repeat (5) tick();
        n_tests++; if (bus.irq_req !== 1'b0) begin n_fail++;
            $display("FAIL seq_hold: req got %b want 0 while ch0 in service", bus.irq_req); end
        do_eret(); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.irq_entr} !== {1'b1, 2'd1, 10'h143}) begin
            n_fail++; $display("FAIL seq_ch1: got req=%b num=%0d entr=%h want 1/1/143",
                               bus.irq_req, bus.irq_num, bus.irq_entr); end
        do_ack();
        n_tests++; if (bus.in_service !== 3'b010) begin n_fail++;
            $display("FAIL seq_ack1: isv got %b want 010", bus.in_service); end
        do_eret(); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.irq_entr} !== {1'b1, 2'd2, 10'h163}) begin
            n_fail++; $display("FAIL seq_ch2: got req=%b num=%0d entr=%h want 1/2/163",
                               bus.irq_req, bus.irq_num, bus.irq_entr); end
        do_ack(); do_eret();
    endtask

    task automatic test_masking();
        bit quiet = 1;
        bus.irq_mask = 3'b011;
        pulse_src(3'b100);
        for (int i = 0; i < 20; i++) begin
            if (bus.irq_req !== 1'b0) quiet = 0;
            tick();
        end
        n_tests++; if (quiet !== 1'b1) begin n_fail++;
            $display("FAIL mask_block: request seen %b want none while masked", !quiet); end
        bus.irq_mask = 3'b111; tick();
        n_tests++; if ({bus.irq_req, bus.irq_num} !== {1'b1, 2'd2}) begin n_fail++;
            $display("FAIL mask_unmask: got req=%b num=%0d want 1/2", bus.irq_req, bus.irq_num); end
        bus.irq_mask = 3'b011; tick();
        n_tests++; if (bus.irq_req !== 1'b0) begin n_fail++;
            $display("FAIL mask_withdraw: req got %b want 0", bus.irq_req); end
        bus.irq_mask = 3'b111; tick();
        n_tests++; if ({bus.irq_req, bus.irq_num} !== {1'b1, 2'd2}) begin n_fail++;
            $display("FAIL mask_kept: got req=%b num=%0d want 1/2", bus.irq_req, bus.irq_num); end
        do_ack(); do_eret();
    endtask

    task automatic test_vector_write();
        vt_write(1, 'h2AB);
        pulse_src(3'b010); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.irq_entr} !== {1'b1, 2'd1, 10'h2AB}) begin
            n_fail++; $display("FAIL vt_new: got req=%b num=%0d entr=%h want 1/1/2ab",
                               bus.irq_req, bus.irq_num, bus.irq_entr); end
        vt_write(1, 'h055);
        n_tests++; if ({bus.irq_req, bus.irq_entr} !== {1'b1, 10'h2AB}) begin n_fail++;
            $display("FAIL vt_frozen: got req=%b entr=%h want 1/2ab", bus.irq_req, bus.irq_entr); end
        do_ack(); do_eret();
        vt_write(3, 'h3FF);
        pulse_src(3'b111); tick();
        n_tests++; if ({bus.irq_num, bus.irq_entr} !== {2'd0, 10'h123}) begin n_fail++;
            $display("FAIL vt_oob_ch0: got num=%0d entr=%h want 0/123", bus.irq_num, bus.irq_entr); end
        do_ack(); do_eret(); tick();
        n_tests++; if ({bus.irq_num, bus.irq_entr} !== {2'd1, 10'h055}) begin n_fail++;
            $display("FAIL vt_next: got num=%0d entr=%h want 1/055", bus.irq_num, bus.irq_entr); end
        do_ack(); do_eret(); tick();
        n_tests++; if ({bus.irq_num, bus.irq_entr} !== {2'd2, 10'h163}) begin n_fail++;
            $display("FAIL vt_oob_ch2: got num=%0d entr=%h want 2/163", bus.irq_num, bus.irq_entr); end
        do_ack(); do_eret();
    endtask

    task automatic test_simultaneous();
        pulse_src(3'b001); tick();
        bus.eret = 1; bus.irq_ack = 1; tick(); bus.eret = 0; bus.irq_ack = 0;
        n_tests++; if ({bus.irq_req, bus.in_service} !== {1'b0, 3'b001}) begin n_fail++;
            $display("FAIL sim_eret_ack: got req=%b isv=%b want 0/001", bus.irq_req, bus.in_service); end
        do_eret();
        pulse_src(3'b001); tick();
        bus.irq_src = 3'b001; bus.irq_ack = 1; tick(); bus.irq_src = '0; bus.irq_ack = 0;
        n_tests++; if ({bus.irq_req, bus.in_service} !== {1'b0, 3'b001}) begin n_fail++;
            $display("FAIL sim_edge_ack: got req=%b isv=%b want 0/001", bus.irq_req, bus.in_service); end
        do_eret(); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num} !== {1'b1, 2'd0}) begin n_fail++;
            $display("FAIL sim_rereq: got req=%b num=%0d want 1/0", bus.irq_req, bus.irq_num); end
        do_ack(); do_eret();
        n_tests++; if (bus.in_service !== 3'b000) begin n_fail++;
            $display("FAIL sim_clean: isv got %b want 000", bus.in_service); end
    endtask

    task automatic test_reset_mid_req();
        bit quiet = 1;
        pulse_src(3'b110); tick();
        rst = 1; bus.irq_ack = 1; tick(); rst = 0; bus.irq_ack = 0;
        n_tests++; if ({bus.irq_req, bus.in_service, bus.irq_num, bus.irq_entr} !==
                       {1'b0, 3'b000, 2'd0, 10'h0}) begin n_fail++;
            $display("FAIL rst_abort: got req=%b isv=%b num=%0d entr=%h want 0/000/0/000",
                     bus.irq_req, bus.in_service, bus.irq_num, bus.irq_entr); end
        for (int i = 0; i < 5; i++) begin
            if (bus.irq_req !== 1'b0) quiet = 0;
            tick();
        end
        n_tests++; if (quiet !== 1'b1) begin n_fail++;
            $display("FAIL rst_pending: request seen %b want none after reset", !quiet); end
        pulse_src(3'b010); tick();
        n_tests++; if ({bus.irq_num, bus.irq_entr} !== {2'd1, 10'h143}) begin n_fail++;
            $display("FAIL rst_vt: got num=%0d entr=%h want 1/143", bus.irq_num, bus.irq_entr); end
        do_ack(); do_eret();
    endtask

`ifdef IRQ_NESTING_EN
    task automatic test_nesting();
        bit quiet = 1;
        pulse_src(3'b100); tick(); do_ack();
        pulse_src(3'b001); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.irq_entr} !== {1'b1, 2'd0, 10'h123}) begin
            n_fail++; $display("FAIL nest_preempt: got req=%b num=%0d entr=%h want 1/0/123",
                               bus.irq_req, bus.irq_num, bus.irq_entr); end
        do_ack();
        n_tests++; if (bus.in_service !== 3'b101) begin n_fail++;
            $display("FAIL nest_isv: got %b want 101", bus.in_service); end
        pulse_src(3'b010);
        for (int i = 0; i < 5; i++) begin
            if (bus.irq_req !== 1'b0) quiet = 0;
            tick();
        end
        n_tests++; if (quiet !== 1'b1) begin n_fail++;
            $display("FAIL nest_block: request seen %b want none", !quiet); end
        do_eret(); tick();
        n_tests++; if ({bus.irq_req, bus.irq_num, bus.in_service} !== {1'b1, 2'd1, 3'b100}) begin
            n_fail++; $display("FAIL nest_ch1: got req=%b num=%0d isv=%b want 1/1/100",
                               bus.irq_req, bus.irq_num, bus.in_service); end
        bus.eret = 1; bus.irq_ack = 1; tick(); bus.eret = 0; bus.irq_ack = 0;
        n_tests++; if (bus.in_service !== 3'b010) begin n_fail++;
            $display("FAIL nest_eret_ack: got %b want 010", bus.in_service); end
        do_eret();
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        rst = 1; idle_inputs(); model_step(); tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) < 3) bus.irq_src = NCH'($urandom_range(0, 7));
            bus.irq_mask = ($urandom_range(0, 9) < 8) ? '1 : NCH'($urandom_range(0, 7));
            bus.irq_ack  = ($urandom_range(0, 9) < 4);
            bus.eret     = ($urandom_range(0, 19) < 3);
            bus.vt_we    = ($urandom_range(0, 19) == 0);
            bus.vt_idx   = NBIT'($urandom_range(0, 3));
            bus.vt_data  = AW'($urandom);
            model_step();
            tick();
            n_tests++;
            if ({bus.irq_req, bus.irq_num, bus.irq_entr, bus.in_service} !==
                {m_req, NBIT'(m_num), m_entr, m_isv}) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand_cycle %0d: got req=%b num=%0d entr=%h isv=%b want %b/%0d/%h/%b",
                                       c, bus.irq_req, bus.irq_num, bus.irq_entr, bus.in_service,
                                       m_req, m_num, m_entr, m_isv);
                bad++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_priority_sequence();
        test_masking();
        test_vector_write();
        test_simultaneous();
        test_reset_mid_req();
`ifdef IRQ_NESTING_EN
        test_nesting();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
